// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared types and constants for the VGA raster timing block.
//   vga_phase_e  : per-axis raster phase (ACTIVE -> FRONT -> SYNC -> BACK)
//   *_DEF        : 640x480@60 default timing constants
//   phase_next() : phase transition decode from the next count value
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } vga_phase_e;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT_DEF  = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BACK_DEF   = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BACK_DEF   = 33;

  // A phase is left on the step whose new count equals the first count of
  // the following phase; BACK hands over to ACTIVE when the count wraps to 0.
  function automatic vga_phase_e phase_next(
    input vga_phase_e       phase,
    input logic [CNT_W-1:0] cnt_next,
    input logic [CNT_W-1:0] front_start,
    input logic [CNT_W-1:0] sync_start,
    input logic [CNT_W-1:0] back_start
  );
    phase_next = phase;
    case (phase)
      ACTIVE:  if (cnt_next == front_start) phase_next = FRONT;
      FRONT:   if (cnt_next == sync_start)  phase_next = SYNC;
      SYNC:    if (cnt_next == back_start)  phase_next = BACK;
      default: if (cnt_next == '0)          phase_next = ACTIVE;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_axis_fsm.sv
// ---------------------------------------------------------------------------
// vga_axis_fsm
// One raster axis: a wrapping counter plus its ACTIVE/FRONT/SYNC/BACK phase.
// Ports:
//   i_clk, i_reset  clock, asynchronous active-high reset (to park value)
//   i_step          advance the counter by one this cycle
//   i_park          synchronously force the park value (overrides i_step)
//   o_count         registered counter, 0..TOTAL-1
//   o_phase         registered phase
//   o_phase_next    phase value that will be loaded on the coming edge
//   o_wrap          this cycle's step takes the counter TOTAL-1 -> 0
// ---------------------------------------------------------------------------
module vga_axis_fsm
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE_LEN = H_ACTIVE_DEF,
  parameter int FRONT_LEN  = H_FRONT_DEF,
  parameter int SYNC_LEN   = H_SYNC_DEF,
  parameter int BACK_LEN   = H_BACK_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_step,
  input  logic             i_park,
  output logic [CNT_W-1:0] o_count,
  output vga_phase_e       o_phase,
  output vga_phase_e       o_phase_next,
  output logic             o_wrap
);

  localparam int               TOTAL       = ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;
  localparam logic [CNT_W-1:0] LAST        = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] FRONT_START = CNT_W'(ACTIVE_LEN);
  localparam logic [CNT_W-1:0] SYNC_START  = CNT_W'(ACTIVE_LEN + FRONT_LEN);
  localparam logic [CNT_W-1:0] BACK_START  = CNT_W'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  vga_phase_e       r_phase;
  vga_phase_e       w_phase_next;

  // State register; park value is the last count of the frame in BACK so the
  // very next step lands on count 0 / ACTIVE.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= LAST;
      r_phase <= BACK;
    end else begin
      r_count <= w_count_next;
      r_phase <= w_phase_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_count_next = r_count;
    w_phase_next = r_phase;
    if (i_park) begin
      w_count_next = LAST;
      w_phase_next = BACK;
    end else if (i_step) begin
      w_count_next = (r_count == LAST) ? '0 : r_count + CNT_W'(1);
      w_phase_next = phase_next(r_phase, w_count_next, FRONT_START, SYNC_START, BACK_START);
    end
  end

  // Outputs
  always_comb begin
    o_count      = r_count;
    o_phase      = r_phase;
    o_phase_next = w_phase_next;
    o_wrap       = i_step && !i_park && (r_count == LAST);
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// vga_timing_ctrl
// VGA raster sequencer advanced by the 1-in-4 pixel tick. Produces counters,
// sync levels, display enable and line/frame strobes, all registered on the
// same edge as the counters.
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to add o_frame_cnt, a
// 16-bit count of frame_start pulses (held while the raster is parked).
// Ports:
//   i_clk          system clock
//   i_reset        asynchronous active-high reset
//   i_pclk         pixel tick enable (1-clk pulse)
//   i_en           raster run enable; low parks the raster at end-of-frame
//   o_h_sync       horizontal sync, level SYNC_POL while asserted
//   o_v_sync       vertical sync, level SYNC_POL while asserted
//   o_disp_en      both axes in ACTIVE
//   o_x_pixel      horizontal count 0..H_TOTAL-1
//   o_y_pixel      vertical count 0..V_TOTAL-1
//   o_line_start   1-clk pulse when x becomes 0
//   o_frame_start  1-clk pulse when x and y both become 0
//   o_frame_cnt    (VGA_TIMING_FRAME_CNT_EN only) frame_start counter
// ---------------------------------------------------------------------------
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FRONT  = H_FRONT_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FRONT  = V_FRONT_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BACK   = V_BACK_DEF,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_pclk,
  input  logic             i_en,
  output logic             o_h_sync,
  output logic             o_v_sync,
  output logic             o_disp_en,
  output logic [CNT_W-1:0] o_x_pixel,
  output logic [CNT_W-1:0] o_y_pixel,
  output logic             o_line_start,
  output logic             o_frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]      o_frame_cnt
`endif
);

  logic       w_step;
  logic       w_park;
  logic       w_h_wrap;
  logic       w_v_wrap;
  vga_phase_e w_h_phase;
  vga_phase_e w_v_phase;
  vga_phase_e w_h_phase_next;
  vga_phase_e w_v_phase_next;

  logic r_h_sync;
  logic r_v_sync;
  logic r_disp_en;
  logic r_line_start;
  logic r_frame_start;

  assign w_step = i_pclk & i_en;
  assign w_park = ~i_en;

  vga_axis_fsm #(
    .ACTIVE_LEN (H_ACTIVE),
    .FRONT_LEN  (H_FRONT),
    .SYNC_LEN   (H_SYNC),
    .BACK_LEN   (H_BACK)
  ) u_h_axis (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_step       (w_step),
    .i_park       (w_park),
    .o_count      (o_x_pixel),
    .o_phase      (w_h_phase),
    .o_phase_next (w_h_phase_next),
    .o_wrap       (w_h_wrap)
  );

  // The vertical axis advances once per horizontal wrap.
  vga_axis_fsm #(
    .ACTIVE_LEN (V_ACTIVE),
    .FRONT_LEN  (V_FRONT),
    .SYNC_LEN   (V_SYNC),
    .BACK_LEN   (V_BACK)
  ) u_v_axis (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_step       (w_h_wrap),
    .i_park       (w_park),
    .o_count      (o_y_pixel),
    .o_phase      (w_v_phase),
    .o_phase_next (w_v_phase_next),
    .o_wrap       (w_v_wrap)
  );

  // Decoding the *next* phase keeps these registers aligned with the
  // counters they describe (no extra cycle of latency).
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_h_sync      <= ~SYNC_POL;
      r_v_sync      <= ~SYNC_POL;
      r_disp_en     <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_h_sync      <= (w_h_phase_next == SYNC) ? SYNC_POL : ~SYNC_POL;
      r_v_sync      <= (w_v_phase_next == SYNC) ? SYNC_POL : ~SYNC_POL;
      r_disp_en     <= (w_h_phase_next == ACTIVE) && (w_v_phase_next == ACTIVE);
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_h_wrap & w_v_wrap;
    end
  end

  assign o_h_sync      = r_h_sync;
  assign o_v_sync      = r_v_sync;
  assign o_disp_en     = r_disp_en;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_frame_cnt <= '0;
    end else if (w_h_wrap & w_v_wrap) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
`endif

endmodule
